// File: rtl/instr_issue_encoder.sv
// Packs {op, rs, rt, rd_imm} request fields into 8-bit instruction words and queues them for instruction load.
// Optional ENC_NOP_FILTER_EN: drop requests that only write $0 (R-type rd=0, load rt=0) and count them.
module instr_issue_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [1:0]               rs,
    input  logic [1:0]               rt,
    input  logic [1:0]               rd_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         issued,
    output logic [CNT_W-1:0]         dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [7:0]       enc_word_reg;
    logic             enc_valid_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [CNT_W-1:0] issued_reg;

    logic has_room;
    logic accept;
    logic push;
    logic pop;
    logic drop_req;
    logic load_enc;

    // Room is judged on the pre-pop occupancy, so a full FIFO never pushes even while popping.
    assign has_room = (count_reg != FULL_COUNT);
    assign in_ready = !flush && (!enc_valid_reg || has_room);
    assign accept   = in_valid && in_ready;
    assign push     = enc_valid_reg && has_room && !flush;
    assign pop      = out_valid && out_ready && !flush;
    assign load_enc = accept && !drop_req;

`ifdef ENC_NOP_FILTER_EN
    logic [CNT_W-1:0] dropped_reg;

    assign drop_req = ((op == 2'b00) && (rd_imm == 2'b00)) ||
                      ((op == 2'b01) && (rt == 2'b00));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            dropped_reg <= '0;
        end else if (accept && drop_req) begin
            dropped_reg <= dropped_reg + CNT_W'(1);
        end
    end

    assign dropped = dropped_reg;
`else
    assign drop_req = 1'b0;
    assign dropped  = '0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            enc_valid_reg <= 1'b0;
            enc_word_reg  <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            issued_reg    <= '0;
        end else if (flush) begin
            enc_valid_reg <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            if (load_enc) begin
                enc_word_reg  <= {op, rs, rt, rd_imm};
                enc_valid_reg <= 1'b1;
            end else if (push) begin
                enc_valid_reg <= 1'b0;
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                issued_reg <= issued_reg + CNT_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK) begin
                if (push && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= enc_word_reg;
                end
            end
        end
    endgenerate

    assign out_valid = (count_reg != '0);
    assign out_instr = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign issued    = issued_reg;
endmodule
